sort_result_serializer: RTL and testbench

- Downstream stage of the 3-input sorter: captures each sorted triple {no1,no2,no3} into a triple-wide FIFO.
- Replays the stored triples one element per cycle on a valid/ready stream, in order no1, no2, no3, with a last flag on no3.
- Checks that every accepted triple is monotonic and raises a sticky error flag on any violation.
- Decouples the sorter's one-triple-per-cycle output rate from a slower serial consumer.

---
 rtl/sort_pkg.sv | 23 ++
 rtl/sort_triple_fifo.sv | 67 ++++++
 rtl/sort_result_serializer.sv | 104 ++++++++++
 tb/tb_sort_result_serializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the 3-input sorter datapath.
// Holds element width, sort-direction codes and the triple bundle.
package sort_pkg;

    localparam int SORT_WIDTH = 3;

    localparam bit ORDER_ASC  = 1'b0;
    localparam bit ORDER_DESC = 1'b1;

    typedef struct packed {
        logic [SORT_WIDTH-1:0] no1;
        logic [SORT_WIDTH-1:0] no2;
        logic [SORT_WIDTH-1:0] no3;
    } sort_triple_t;

    // Position of the element currently presented from the head triple
    typedef enum logic [1:0] {
        S_E1 = 2'd0,
        S_E2 = 2'd1,
        S_E3 = 2'd2
    } ser_idx_t;

endpackage

// File: rtl/sort_triple_fifo.sv
// Synchronous FIFO of packed triples with occupancy count.
// Callers gate push with !full and pop with !empty.
module sort_triple_fifo
    import sort_pkg::*;
#(
    parameter type T     = sort_triple_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);

    // Next-state for pointers and occupancy; pointers wrap by width
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sort_result_serializer.sv
// Buffers sorted triples and replays them one element per cycle.
// Also flags any accepted triple that breaks the expected order.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int DEPTH = 4,
    parameter bit ORDER = ORDER_DESC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       no1,
    input  logic [WIDTH-1:0]       no2,
    input  logic [WIDTH-1:0]       no3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] count,
    output logic                   order_err
);

    typedef struct packed {
        logic [WIDTH-1:0] no1;
        logic [WIDTH-1:0] no2;
        logic [WIDTH-1:0] no3;
    } trip_t;

    trip_t    wdata;
    trip_t    head;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;
    logic     hs;
    logic     misordered;
    ser_idx_t idx_q;
    logic     err_q;

    assign wdata    = '{no1: no1, no2: no2, no3: no3};
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign out_valid = !empty && !rst;
    assign hs       = out_valid && out_ready;
    assign pop      = hs && (idx_q == S_E3);
    assign out_last = out_valid && (idx_q == S_E3);
    assign order_err = err_q;

    sort_triple_fifo #(
        .T     (trip_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Pick the element of the head triple selected by idx
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (idx_q)
                S_E1:    out_data = head.no1;
                S_E2:    out_data = head.no2;
                S_E3:    out_data = head.no3;
                default: out_data = '0;
            endcase
        end
    end

    // Order violation test on the incoming triple; ties are legal
    always_comb begin
        if (ORDER == ORDER_DESC)
            misordered = (no1 < no2) || (no2 < no3);
        else
            misordered = (no1 > no2) || (no2 > no3);
    end

    // Element FSM advances on handshakes; error flag is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= S_E1;
            err_q <= 1'b0;
        end else begin
            if (hs) begin
                case (idx_q)
                    S_E1:    idx_q <= S_E2;
                    S_E2:    idx_q <= S_E3;
                    default: idx_q <= S_E1;
                endcase
            end
            if (push && misordered) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed self-checking bench for sort_result_serializer.
// Expected values are hand-derived or taken from a bench-side queue.
module tb_sort_result_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] no1, no2, no3;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       out_last;
    logic [2:0] count;
    logic       order_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sort_result_serializer #(
        .WIDTH (3),
        .DEPTH (4),
        .ORDER (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .no1       (no1),
        .no2       (no2),
        .no3       (no3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (count),
        .order_err (order_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b, input int c);
        in_valid = v;
        no1 = 3'(a);
        no2 = 3'(b);
        no3 = 3'(c);
    endtask

    int bp_tab [5][3] = '{'{6,6,1}, '{5,3,0}, '{7,7,7}, '{4,2,1}, '{3,1,0}};
    int bp_exp [12]   = '{6,6,1, 5,3,0, 7,7,7, 4,2,1};
    int q [$];
    int pushed;
    int cyc;
    int a, b, c;
    int exp_d;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 0, 0, 0);

        // Reset and idle
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        tick();
        check("rst_in_ready2", in_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_count", count, 0);
        check("idle_err", order_err, 0);

        // Single triple
        out_ready = 1'b1;
        drive(1'b1, 7, 5, 2);
        tick();
        drive(1'b0, 0, 0, 0);
        check("single_count", count, 1);
        check("single_d0", out_data, 7);
        check("single_l0", out_last, 0);
        tick();
        check("single_d1", out_data, 5);
        check("single_l1", out_last, 0);
        tick();
        check("single_d2", out_data, 2);
        check("single_l2", out_last, 1);
        tick();
        check("single_done_v", out_valid, 0);
        check("single_done_c", count, 0);
        check("single_done_d", out_data, 0);

        // Backpressure until full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bp_tab[i][0], bp_tab[i][1], bp_tab[i][2]);
            if (i == 4) check("full_in_ready", in_ready, 0);
            tick();
        end
        drive(1'b0, 0, 0, 0);
        check("full_count", count, 4);
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j == 2) check("full_rdy_pre", in_ready, 0);
            if (j == 3) check("full_rdy_post", in_ready, 1);
            check($sformatf("bp_d%0d", j), out_data, bp_exp[j]);
            check($sformatf("bp_l%0d", j), out_last, (j % 3 == 2) ? 1 : 0);
            tick();
        end
        check("bp_empty", out_valid, 0);
        check("bp_count", count, 0);
        check("bp_err", order_err, 0);

        // Stall mid-triple
        drive(1'b1, 5, 4, 3);
        tick();
        drive(1'b0, 0, 0, 0);
        check("stall_d0", out_data, 5);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_hold_d%0d", k), out_data, 4);
            check($sformatf("stall_hold_l%0d", k), out_last, 0);
            check($sformatf("stall_hold_v%0d", k), out_valid, 1);
        end
        out_ready = 1'b1;
        check("stall_res_d1", out_data, 4);
        tick();
        check("stall_res_d2", out_data, 3);
        check("stall_res_l2", out_last, 1);
        tick();
        check("stall_empty", out_valid, 0);

        // Order violation is sticky
        drive(1'b1, 2, 5, 1);
        tick();
        check("err_set", order_err, 1);
        drive(1'b1, 4, 4, 4);
        tick();
        drive(1'b0, 0, 0, 0);
        check("err_sticky", order_err, 1);
        repeat (8) tick();
        check("err_sticky2", order_err, 1);
        check("err_drain", count, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("err_clear", order_err, 0);
        check("err_clr_cnt", count, 0);

        // Wrap with toggling ready and concurrent push/pop
        pushed = 0;
        cyc = 0;
        while ((pushed < 10 || q.size() != 0) && cyc < 300) begin
            out_ready = (cyc % 2 == 0);
            if (pushed < 10) begin
                a = 7 - (pushed % 2);
                b = (pushed * 3) % 5;
                c = b / 2;
                drive(1'b1, a, b, c);
            end else begin
                drive(1'b0, 0, 0, 0);
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("wrap_spurious", 1, 0);
                end else begin
                    exp_d = q.pop_front();
                    check("wrap_data", out_data, exp_d);
                    check("wrap_last", out_last, (q.size() % 3 == 0) ? 1 : 0);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(a);
                q.push_back(b);
                q.push_back(c);
                pushed++;
            end
            tick();
            check("wrap_cnt_le4", (count <= 4) ? 1 : 0, 1);
            cyc++;
        end
        drive(1'b0, 0, 0, 0);
        check("wrap_timeout", (cyc < 300) ? 1 : 0, 1);
        check("wrap_pushed", pushed, 10);
        check("wrap_err", order_err, 0);
        check("wrap_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
